game_state_nxn: RTL



---
 rtl/game_state_nxn_if.sv | 12 +
 rtl/game_state_nxn.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_nxn_if.sv
// rtl/game_state_nxn_if.sv - move-request handshake between the move sources and the game core
interface game_state_nxn_if #(
  parameter int IDX_W = 4
);
  logic             mv_valid;
  logic             mv_ready;
  logic             mv_player;
  logic [IDX_W-1:0] mv_idx;

  modport master (output mv_valid, output mv_player, output mv_idx, input mv_ready);
  modport slave  (input mv_valid, input mv_player, input mv_idx, output mv_ready);
endinterface

// File: rtl/game_state_nxn.sv
// rtl/game_state_nxn.sv - N x N k-in-a-row game-state engine with a 4-cycle line checker
// Defining GAME_UNDO_EN adds a one-level take-back of the last legal move.
module game_state_nxn #(
  parameter int N            = 3,
  parameter int WIN_LEN      = 3,
  parameter int SCORE_W      = 8,
  parameter int FIRST_PLAYER = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_game,
  input  logic                 undo_req,
  game_state_nxn_if.slave      mv,
  output logic [N*N-1:0]       x_board,
  output logic [N*N-1:0]       o_board,
  output logic                 turn,
  output logic [2:0]           status,
  output logic                 busy,
  output logic [SCORE_W-1:0]   x_wins,
  output logic [SCORE_W-1:0]   o_wins
);

  localparam int CELLS = N * N;
  localparam int IDX_W = $clog2(CELLS);
  localparam int RC_W  = $clog2(N);

  localparam logic [2:0] ST_PLAY = 3'd0;
  localparam logic [2:0] ST_XWIN = 3'd1;
  localparam logic [2:0] ST_OWIN = 3'd2;
  localparam logic [2:0] ST_DRAW = 3'd3;
  localparam logic [2:0] ST_BAD  = 3'd4;
  localparam logic       FIRST   = 1'(FIRST_PLAYER);

  typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [1:0]         dir_q, dir_d;
  logic [RC_W-1:0]    row_q, row_d;
  logic [RC_W-1:0]    col_q, col_d;
  logic               player_q, player_d;
  logic               win_q, win_d;
  logic [CELLS-1:0]   x_board_q, x_board_d;
  logic [CELLS-1:0]   o_board_q, o_board_d;
  logic               turn_q, turn_d;
  logic [2:0]         status_q, status_d;
  logic [SCORE_W-1:0] x_wins_q, x_wins_d;
  logic [SCORE_W-1:0] o_wins_q, o_wins_d;

`ifdef GAME_UNDO_EN
  logic               hist_valid_q, hist_valid_d;
  logic [IDX_W-1:0]   hist_idx_q, hist_idx_d;
  logic               hist_player_q, hist_player_d;
`endif

  logic               can_play;
  logic               cell_taken;
  logic               mv_legal;
  logic               mv_ready_int;
  logic               mv_fire;
  logic               undo_acc;
  logic [CELLS-1:0]   mover_board;
  logic               fwd_on, bwd_on;
  logic               run_hit;
  logic               line_win;
  int                 dr, dc, run;

  // Out-of-board coordinates never match any cell, so edge clipping falls out for free.
  function automatic logic cell_at(input logic [CELLS-1:0] b, input int r, input int c);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (r == i / N && c == i % N) hit = b[i];
    end
    return hit;
  endfunction

  assign can_play = (status_q == ST_PLAY) || (status_q == ST_BAD);

  always_comb begin
    cell_taken = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (int'(mv.mv_idx) == i) cell_taken = x_board_q[i] | o_board_q[i];
    end
  end

  assign mv_legal = (int'(mv.mv_idx) < CELLS) && !cell_taken &&
                    (mv.mv_player == turn_q) && can_play;

`ifdef GAME_UNDO_EN
  assign undo_acc = undo_req && !new_game && (state_q == IDLE) && can_play && hist_valid_q;
`else
  logic unused_undo;
  assign undo_acc    = 1'b0;
  assign unused_undo = undo_req;
`endif

  assign mv_ready_int = (state_q == IDLE) && !new_game && !undo_acc;
  assign mv_fire      = mv.mv_valid && mv_ready_int;

  // One direction per cycle: count the mover's cells on each side of the latched move.
  always_comb begin
    mover_board = player_q ? x_board_q : o_board_q;
    case (dir_q)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    run    = 1;
    fwd_on = 1'b1;
    bwd_on = 1'b1;
    for (int s = 1; s < WIN_LEN; s++) begin
      if (fwd_on && cell_at(mover_board, int'(row_q) + s * dr, int'(col_q) + s * dc))
        run = run + 1;
      else
        fwd_on = 1'b0;
      if (bwd_on && cell_at(mover_board, int'(row_q) - s * dr, int'(col_q) - s * dc))
        run = run + 1;
      else
        bwd_on = 1'b0;
    end
    run_hit = (run >= WIN_LEN);
  end

  assign line_win = win_q || run_hit;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    row_d     = row_q;
    col_d     = col_q;
    player_d  = player_q;
    win_d     = win_q;
    x_board_d = x_board_q;
    o_board_d = o_board_q;
    turn_d    = turn_q;
    status_d  = status_q;
    x_wins_d  = x_wins_q;
    o_wins_d  = o_wins_q;
`ifdef GAME_UNDO_EN
    hist_valid_d  = hist_valid_q;
    hist_idx_d    = hist_idx_q;
    hist_player_d = hist_player_q;
`endif
    if (new_game) begin
      state_d   = IDLE;
      dir_d     = 2'd0;
      win_d     = 1'b0;
      x_board_d = '0;
      o_board_d = '0;
      turn_d    = FIRST;
      status_d  = ST_PLAY;
`ifdef GAME_UNDO_EN
      hist_valid_d = 1'b0;
`endif
    end
`ifdef GAME_UNDO_EN
    else if (undo_acc) begin
      x_board_d    = x_board_q & ~(CELLS'(1) << hist_idx_q);
      o_board_d    = o_board_q & ~(CELLS'(1) << hist_idx_q);
      turn_d       = hist_player_q;
      status_d     = ST_PLAY;
      hist_valid_d = 1'b0;
    end
`endif
    else if (mv_fire) begin
      if (mv_legal) begin
        if (mv.mv_player) x_board_d = x_board_q | (CELLS'(1) << mv.mv_idx);
        else              o_board_d = o_board_q | (CELLS'(1) << mv.mv_idx);
        row_d    = RC_W'(int'(mv.mv_idx) / N);
        col_d    = RC_W'(int'(mv.mv_idx) % N);
        player_d = mv.mv_player;
        win_d    = 1'b0;
        dir_d    = 2'd0;
        state_d  = CHECK;
`ifdef GAME_UNDO_EN
        hist_valid_d  = 1'b1;
        hist_idx_d    = mv.mv_idx;
        hist_player_d = mv.mv_player;
`endif
      end else if (can_play) begin
        // A finished game keeps its result on display; bad moves only flag during play.
        status_d = ST_BAD;
      end
    end else if (state_q == CHECK) begin
      win_d = line_win;
      dir_d = dir_q + 2'd1;
      if (dir_q == 2'd3) begin
        state_d = IDLE;
        if (line_win) begin
          status_d = player_q ? ST_XWIN : ST_OWIN;
          if (player_q) begin
            if (x_wins_q != '1) x_wins_d = x_wins_q + 1'b1;
          end else begin
            if (o_wins_q != '1) o_wins_d = o_wins_q + 1'b1;
          end
        end else if (&(x_board_q | o_board_q)) begin
          status_d = ST_DRAW;
        end else begin
          status_d = ST_PLAY;
          turn_d   = ~turn_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      dir_q     <= 2'd0;
      row_q     <= '0;
      col_q     <= '0;
      player_q  <= 1'b0;
      win_q     <= 1'b0;
      x_board_q <= '0;
      o_board_q <= '0;
      turn_q    <= FIRST;
      status_q  <= ST_PLAY;
      x_wins_q  <= '0;
      o_wins_q  <= '0;
`ifdef GAME_UNDO_EN
      hist_valid_q  <= 1'b0;
      hist_idx_q    <= '0;
      hist_player_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      row_q     <= row_d;
      col_q     <= col_d;
      player_q  <= player_d;
      win_q     <= win_d;
      x_board_q <= x_board_d;
      o_board_q <= o_board_d;
      turn_q    <= turn_d;
      status_q  <= status_d;
      x_wins_q  <= x_wins_d;
      o_wins_q  <= o_wins_d;
`ifdef GAME_UNDO_EN
      hist_valid_q  <= hist_valid_d;
      hist_idx_q    <= hist_idx_d;
      hist_player_q <= hist_player_d;
`endif
    end
  end

  assign mv.mv_ready = mv_ready_int;
  assign busy        = (state_q == CHECK);
  assign x_board     = x_board_q;
  assign o_board     = o_board_q;
  assign turn        = turn_q;
  assign status      = status_q;
  assign x_wins      = x_wins_q;
  assign o_wins      = o_wins_q;

endmodule
